// File: rtl/pcs_dec.sv
// 64b/66b PCS receive decoder: turns descrambled 32-bit block halves into a
// packet word stream (start/last/keep) with idle and protocol-error pulses.
module pcs_dec #(
  parameter int XGMII_DATA_W = 32,
  parameter int XGMII_KEEP_W = XGMII_DATA_W/8,
  parameter int BLOCK_W      = 64,
  parameter int CNT_N        = BLOCK_W/XGMII_DATA_W,
  parameter int CNT_W        = $clog2(CNT_N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic [CNT_W-1:0]        part_i,
  input  logic [1:0]              sync_header_i,
  input  logic [XGMII_DATA_W-1:0] data_i,
  output logic                    valid_o,
  output logic [XGMII_DATA_W-1:0] data_o,
  output logic [XGMII_KEEP_W-1:0] keep_o,
  output logic                    start_o,
  output logic                    last_o,
  output logic                    idle_o,
  output logic                    err_o,
  output logic                    dbg_state
);

  // Handshake: no backpressure. valid_i qualifies each input word; valid_o
  // qualifies data_o/keep_o, and keep_o is all-zero whenever valid_o is low.

  typedef enum logic {ST_IDLE, ST_DATA} state_t;
  typedef enum logic [1:0] {ACT_DROP, ACT_START, ACT_DATA, ACT_TERM} act_t;

  state_t state, state_nxt;
  act_t   blk_act, blk_act_nxt;
  logic [2:0] blk_term, blk_term_nxt;

  logic                    h_valid, h_start, h_last, h_idle, h_err;
  logic                    h_valid_nxt, h_start_nxt, h_last_nxt, h_idle_nxt, h_err_nxt;
  logic [XGMII_DATA_W-1:0] h_data, h_data_nxt;
  logic [XGMII_KEEP_W-1:0] h_keep, h_keep_nxt;

  logic       first, hdr_data, hdr_ctrl;
  logic       is_ctrl, is_start, is_term;
  logic [2:0] term_n;
  logic       force_last, abort;

  function automatic logic [XGMII_KEEP_W-1:0] keep_part0(input logic [2:0] n);
    case (n)
      3'd0:    return XGMII_KEEP_W'(4'b0000);
      3'd1:    return XGMII_KEEP_W'(4'b0010);
      3'd2:    return XGMII_KEEP_W'(4'b0110);
      default: return XGMII_KEEP_W'(4'b1110);
    endcase
  endfunction

  function automatic logic [XGMII_KEEP_W-1:0] keep_part1(input logic [2:0] n);
    case (n)
      3'd4:    return XGMII_KEEP_W'(4'b0001);
      3'd5:    return XGMII_KEEP_W'(4'b0011);
      3'd6:    return XGMII_KEEP_W'(4'b0111);
      3'd7:    return XGMII_KEEP_W'(4'b1111);
      default: return XGMII_KEEP_W'(4'b0000);
    endcase
  endfunction

  assign first    = (part_i == '0);
  assign hdr_data = (sync_header_i == 2'b01);
  assign hdr_ctrl = (sync_header_i == 2'b10);

  always_comb begin
    is_ctrl  = 1'b0;
    is_start = 1'b0;
    is_term  = 1'b0;
    term_n   = 3'd0;
    case (data_i[7:0])
      8'h1e: is_ctrl  = 1'b1;
      8'h78: is_start = 1'b1;
      8'h87: begin is_term = 1'b1; term_n = 3'd0; end
      8'h99: begin is_term = 1'b1; term_n = 3'd1; end
      8'haa: begin is_term = 1'b1; term_n = 3'd2; end
      8'hb4: begin is_term = 1'b1; term_n = 3'd3; end
      8'hcc: begin is_term = 1'b1; term_n = 3'd4; end
      8'hd2: begin is_term = 1'b1; term_n = 3'd5; end
      8'he1: begin is_term = 1'b1; term_n = 3'd6; end
      8'hff: begin is_term = 1'b1; term_n = 3'd7; end
      default: ;
    endcase
  end

  // Block action is decided on part 0 and replayed for the remaining part.
  // The FSM leaves DATA on the word that carries last, so TERM_4..7 stay in
  // DATA through part 1 and a dropped valid there still aborts the packet.
  always_comb begin
    state_nxt    = state;
    blk_act_nxt  = blk_act;
    blk_term_nxt = blk_term;
    h_valid_nxt  = 1'b0;
    h_start_nxt  = 1'b0;
    h_last_nxt   = 1'b0;
    h_idle_nxt   = 1'b0;
    h_err_nxt    = 1'b0;
    h_data_nxt   = '0;
    h_keep_nxt   = '0;
    force_last   = 1'b0;
    abort        = 1'b0;

    if (state == ST_IDLE) begin
      if (valid_i && first) begin
        blk_act_nxt  = ACT_DROP;
        blk_term_nxt = term_n;
        if (hdr_ctrl && is_start) begin
          state_nxt   = ST_DATA;
          blk_act_nxt = ACT_START;
          h_valid_nxt = 1'b1;
          h_start_nxt = 1'b1;
          h_data_nxt  = data_i;
          h_keep_nxt  = XGMII_KEEP_W'(4'b1110);
        end else if (hdr_ctrl && is_ctrl) begin
          h_idle_nxt = 1'b1;
        end else begin
          h_err_nxt = 1'b1;
        end
      end
    end else begin
      if (!valid_i) begin
        abort = 1'b1;
      end else if (first) begin
        if (hdr_data) begin
          blk_act_nxt = ACT_DATA;
          h_valid_nxt = 1'b1;
          h_data_nxt  = data_i;
          h_keep_nxt  = '1;
        end else if (hdr_ctrl && is_term) begin
          blk_act_nxt  = ACT_TERM;
          blk_term_nxt = term_n;
          if (term_n == 3'd0) begin
            force_last = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            h_valid_nxt = 1'b1;
            h_data_nxt  = data_i;
            h_keep_nxt  = keep_part0(term_n);
            if (term_n < 3'd4) begin
              h_last_nxt = 1'b1;
              state_nxt  = ST_IDLE;
            end
          end
        end else begin
          abort = 1'b1;
        end
      end else begin
        h_valid_nxt = 1'b1;
        h_data_nxt  = data_i;
        if (blk_act == ACT_TERM) begin
          h_keep_nxt = keep_part1(blk_term);
          h_last_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          h_keep_nxt = '1;
        end
      end
      if (abort) begin
        state_nxt   = ST_IDLE;
        blk_act_nxt = ACT_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      blk_act  <= ACT_DROP;
      blk_term <= 3'd0;
      h_valid  <= 1'b0;
      h_start  <= 1'b0;
      h_last   <= 1'b0;
      h_idle   <= 1'b0;
      h_err    <= 1'b0;
      h_data   <= '0;
      h_keep   <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
      keep_o   <= '0;
      start_o  <= 1'b0;
      last_o   <= 1'b0;
      idle_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      blk_act  <= blk_act_nxt;
      blk_term <= blk_term_nxt;
      h_valid  <= h_valid_nxt;
      h_start  <= h_start_nxt;
      h_last   <= h_last_nxt;
      h_idle   <= h_idle_nxt;
      h_err    <= h_err_nxt;
      h_data   <= h_data_nxt;
      h_keep   <= h_keep_nxt;
      // TERM_0 and aborts close the packet on the word already held.
      valid_o  <= h_valid;
      data_o   <= h_data;
      keep_o   <= h_keep;
      start_o  <= h_start;
      last_o   <= h_last | (h_valid & (force_last | abort));
      idle_o   <= h_idle;
      err_o    <= h_err | abort;
    end
  end

  assign dbg_state = (state == ST_DATA);

endmodule
